// File: rtl/seq_det_ctrl.sv
// Serial pattern detector with run control, match counting and an optional
// idle timeout that is compiled in only when SEQ_DET_TIMEOUT_EN is defined.
module seq_det_ctrl #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int TMO_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [PAT_W-1:0] cfg_pattern_i,
    input  logic             cfg_overlap_i,
    input  logic [CNT_W-1:0] cfg_limit_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             in_i,
    input  logic             in_valid_i,
    output logic             out_o,
    output logic [CNT_W-1:0] match_cnt_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o
);

    // state | meaning
    // IDLE  | waiting for config or start; cfg accepted
    // RUN   | shifting serial bits and counting matches
    // DONE  | run ended by limit or timeout; cfg accepted
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX   = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_READY = FILL_W'(PAT_W - 1);
    localparam logic [TMO_W-1:0]  TMO_LOAD   = '1;

    state_t             state_q;
    logic [PAT_W-1:0]   pattern_q;
    logic               overlap_q;
    logic [CNT_W-1:0]   limit_q;
    logic [PAT_W-1:0]   hist_q;
    logic [FILL_W-1:0]  fill_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               out_q;

    logic [PAT_W-1:0]   cand_d;
    logic               hit_d;
    logic [CNT_W-1:0]   cnt_plus_d;
    logic [CNT_W-1:0]   cnt_sat_d;
    logic               limit_hit_d;

    always_comb begin
        cand_d      = {hist_q[PAT_W-2:0], in_i};
        hit_d       = in_valid_i && (fill_q >= FILL_READY) && (cand_d == pattern_q);
        cnt_plus_d  = cnt_q + 1'b1;
        cnt_sat_d   = (cnt_q == '1) ? cnt_q : cnt_plus_d;
        limit_hit_d = (limit_q != '0) && (cnt_plus_d == limit_q);
    end

`ifdef SEQ_DET_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);
    logic [TMO_W-1:0] tmo_q;
    logic             timeout_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            pattern_q <= '0;
            overlap_q <= 1'b0;
            limit_q   <= '0;
            hist_q    <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
            out_q     <= 1'b0;
`ifdef SEQ_DET_TIMEOUT_EN
            tmo_q     <= TMO_LOAD;
            timeout_q <= 1'b0;
`endif
        end else begin
            out_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    // A config handshake wins over a same-cycle start.
                    if (cfg_valid_i) begin
                        pattern_q <= cfg_pattern_i;
                        overlap_q <= cfg_overlap_i;
                        limit_q   <= cfg_limit_i;
                    end else if (start_i) begin
                        state_q <= S_RUN;
                        cnt_q   <= '0;
                        hist_q  <= '0;
                        fill_q  <= '0;
`ifdef SEQ_DET_TIMEOUT_EN
                        tmo_q     <= TMO_LOAD;
                        timeout_q <= 1'b0;
`endif
                    end
                end
                S_RUN: begin
                    if (stop_i) begin
                        state_q <= S_IDLE;
                    end else if (in_valid_i) begin
`ifdef SEQ_DET_TIMEOUT_EN
                        tmo_q <= TMO_LOAD;
`endif
                        if (hit_d) begin
                            out_q <= 1'b1;
                            cnt_q <= cnt_sat_d;
                            if (overlap_q) begin
                                hist_q <= cand_d;
                            end else begin
                                hist_q <= '0;
                                fill_q <= '0;
                            end
                            if (limit_hit_d) begin
                                state_q <= S_DONE;
                            end
                        end else begin
                            hist_q <= cand_d;
                            if (fill_q != FILL_MAX) begin
                                fill_q <= fill_q + 1'b1;
                            end
                        end
                    end
`ifdef SEQ_DET_TIMEOUT_EN
                    // Down-counter reloads on every valid bit; terminal count ends the run.
                    else if (tmo_q == TMO_ONE) begin
                        tmo_q     <= '0;
                        timeout_q <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        tmo_q <= tmo_q - 1'b1;
                    end
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cfg_ready_o = (state_q != S_RUN);
    assign busy_o      = (state_q == S_RUN);
    assign done_o      = (state_q == S_DONE);
    assign out_o       = out_q;
    assign match_cnt_o = cnt_q;

`ifdef SEQ_DET_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    // Constant zero; TMO_LOAD is referenced only so the width parameter stays used.
    assign timeout_o = TMO_LOAD[0] & 1'b0;
`endif

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: a vector table for the main run/config
// behaviour plus hand-written sequences for saturation, reset and timeout.
module tb_seq_det_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       cfg_valid_i;
    logic       cfg_ready_o;
    logic [3:0] cfg_pattern_i;
    logic       cfg_overlap_i;
    logic [7:0] cfg_limit_i;
    logic       start_i;
    logic       stop_i;
    logic       in_i;
    logic       in_valid_i;
    logic       out_o;
    logic [7:0] match_cnt_o;
    logic       busy_o;
    logic       done_o;
    logic       timeout_o;

    int total = 0;
    int bad   = 0;

    seq_det_ctrl #(.PAT_W(4), .CNT_W(8), .TMO_W(3)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .cfg_pattern_i(cfg_pattern_i), .cfg_overlap_i(cfg_overlap_i),
        .cfg_limit_i(cfg_limit_i), .start_i(start_i), .stop_i(stop_i),
        .in_i(in_i), .in_valid_i(in_valid_i), .out_o(out_o),
        .match_cnt_o(match_cnt_o), .busy_o(busy_o), .done_o(done_o),
        .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       cv;
        logic [3:0] pat;
        logic       ov;
        logic [7:0] lim;
        logic       st;
        logic       sp;
        logic       iv;
        logic       b;
        logic       eo;
        logic [7:0] ec;
        logic       eb;
        logic       ed;
        logic       er;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic cv, input logic [3:0] pat, input logic ov,
                       input logic [7:0] lim, input logic st, input logic sp,
                       input logic iv, input logic b, input logic eo,
                       input logic [7:0] ec, input logic eb, input logic ed,
                       input logic er);
        vec_t v;
        v.cv = cv; v.pat = pat; v.ov = ov; v.lim = lim; v.st = st; v.sp = sp;
        v.iv = iv; v.b = b; v.eo = eo; v.ec = ec; v.eb = eb; v.ed = ed; v.er = er;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic cv, input logic st, input logic sp,
                         input logic iv, input logic b);
        cfg_valid_i = cv; start_i = st; stop_i = sp; in_valid_i = iv; in_i = b;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all(input string tag, input logic eo, input logic [7:0] ec,
                             input logic eb, input logic ed, input logic er);
        chk({tag, ".out"}, out_o, eo);
        chk({tag, ".cnt"}, match_cnt_o, ec);
        chk({tag, ".busy"}, busy_o, eb);
        chk({tag, ".done"}, done_o, ed);
        chk({tag, ".ready"}, cfg_ready_o, er);
    endtask

    initial begin
        rst_i = 1'b1;
        cfg_pattern_i = '0; cfg_overlap_i = 1'b0; cfg_limit_i = '0;
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        check_all("reset", 0, 0, 0, 0, 1);
        chk("reset.timeout", timeout_o, 0);
        rst_i = 1'b0;

        // overlap=1, limit=0: stream 0110110 pulses after bit 4 and bit 7
        add(1,4'b0110,1,0, 0,0,0,0, 0,0,0,0,1);
        add(0,0,0,0, 1,0,0,0, 0,0,1,0,0);
        add(0,0,0,0, 0,0,1,0, 0,0,1,0,0);
        add(0,0,0,0, 0,0,1,1, 0,0,1,0,0);
        add(0,0,0,0, 0,0,1,1, 0,0,1,0,0);
        add(0,0,0,0, 0,0,1,0, 1,1,1,0,0);
        add(0,0,0,0, 0,0,1,1, 0,1,1,0,0);
        add(0,0,0,0, 0,0,1,1, 0,1,1,0,0);
        add(0,0,0,0, 0,0,1,0, 1,2,1,0,0);
        add(0,0,0,0, 0,0,0,0, 0,2,1,0,0);
        add(0,0,0,0, 0,1,0,0, 0,2,0,0,1);
        // overlap=0: only one pulse on the same stream
        add(1,4'b0110,0,0, 0,0,0,0, 0,2,0,0,1);
        add(0,0,0,0, 1,0,0,0, 0,0,1,0,0);
        add(0,0,0,0, 0,0,1,0, 0,0,1,0,0);
        add(0,0,0,0, 0,0,1,1, 0,0,1,0,0);
        add(0,0,0,0, 0,0,1,1, 0,0,1,0,0);
        add(0,0,0,0, 0,0,1,0, 1,1,1,0,0);
        add(0,0,0,0, 0,0,1,1, 0,1,1,0,0);
        add(0,0,0,0, 0,0,1,1, 0,1,1,0,0);
        add(0,0,0,0, 0,0,1,0, 0,1,1,0,0);
        add(0,0,0,0, 0,1,0,0, 0,1,0,0,1);
        // limit=1: first match ends the run, the second copy is ignored
        add(1,4'b0110,1,1, 0,0,0,0, 0,1,0,0,1);
        add(0,0,0,0, 1,0,0,0, 0,0,1,0,0);
        add(0,0,0,0, 0,0,1,0, 0,0,1,0,0);
        add(0,0,0,0, 0,0,1,1, 0,0,1,0,0);
        add(0,0,0,0, 0,0,1,1, 0,0,1,0,0);
        add(0,0,0,0, 0,0,1,0, 1,1,0,1,1);
        add(0,0,0,0, 0,0,1,0, 0,1,0,1,1);
        add(0,0,0,0, 0,0,1,1, 0,1,0,1,1);
        add(0,0,0,0, 0,0,1,1, 0,1,0,1,1);
        add(0,0,0,0, 0,0,1,0, 0,1,0,1,1);
        add(0,0,0,0, 0,1,0,0, 0,1,0,1,1);
        // cfg + start together: config taken, start ignored, stays DONE
        add(1,4'b0110,1,0, 1,0,0,0, 0,1,0,1,1);
        add(0,0,0,0, 1,0,0,0, 0,0,1,0,0);
        // gapped bits: pulse one cycle after the last valid bit only
        add(0,0,0,0, 0,0,1,0, 0,0,1,0,0);
        for (int g = 0; g < 3; g++) add(0,0,0,0, 0,0,0,0, 0,0,1,0,0);
        add(0,0,0,0, 0,0,1,1, 0,0,1,0,0);
        for (int g = 0; g < 3; g++) add(0,0,0,0, 0,0,0,0, 0,0,1,0,0);
        add(0,0,0,0, 0,0,1,1, 0,0,1,0,0);
        for (int g = 0; g < 3; g++) add(0,0,0,0, 0,0,0,0, 0,0,1,0,0);
        add(0,0,0,0, 0,0,1,0, 1,1,1,0,0);
        add(0,0,0,0, 0,0,0,0, 0,1,1,0,0);
        add(0,0,0,0, 0,1,0,0, 0,1,0,0,1);
        // stop on the completing bit: no pulse, no count
        add(0,0,0,0, 1,0,0,0, 0,0,1,0,0);
        add(0,0,0,0, 0,0,1,0, 0,0,1,0,0);
        add(0,0,0,0, 0,0,1,1, 0,0,1,0,0);
        add(0,0,0,0, 0,0,1,1, 0,0,1,0,0);
        add(0,0,0,0, 0,1,1,0, 0,0,0,0,1);
        add(0,0,0,0, 0,0,0,0, 0,0,0,0,1);

        for (int i = 0; i < tbl.size(); i++) begin
            cfg_pattern_i = tbl[i].pat; cfg_overlap_i = tbl[i].ov; cfg_limit_i = tbl[i].lim;
            drive(tbl[i].cv, tbl[i].st, tbl[i].sp, tbl[i].iv, tbl[i].b);
            tick();
            check_all($sformatf("vec%0d", i), tbl[i].eo, tbl[i].ec, tbl[i].eb,
                      tbl[i].ed, tbl[i].er);
        end

        // saturation: pattern 1111 overlapped, every one after the third matches
        cfg_pattern_i = 4'b1111; cfg_overlap_i = 1'b1; cfg_limit_i = 8'd0;
        drive(1, 0, 0, 0, 0); tick();
        drive(0, 1, 0, 0, 0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 1); tick();
        end
        chk("sat.pre_cnt", match_cnt_o, 0);
        for (int i = 0; i < 260; i++) begin
            drive(0, 0, 0, 1, 1); tick();
        end
        chk("sat.cnt", match_cnt_o, 8'hFF);
        chk("sat.out", out_o, 1);
        chk("sat.busy", busy_o, 1);

        // reset on a matching bit drops the pulse and clears everything
        drive(0, 0, 0, 1, 1); rst_i = 1'b1; tick();
        rst_i = 1'b0;
        drive(0, 0, 0, 0, 0);
        check_all("rst_mid", 0, 0, 0, 0, 1);
        chk("rst_mid.timeout", timeout_o, 0);

        // reset cleared the pattern to 0000, non-overlap, unlimited
        drive(0, 1, 0, 0, 0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 0); tick();
        end
        chk("zero_pat.pre", out_o, 0);
        drive(0, 0, 0, 1, 0); tick();
        chk("zero_pat.out", out_o, 1);
        chk("zero_pat.cnt", match_cnt_o, 1);
        drive(0, 0, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 0);

`ifdef SEQ_DET_TIMEOUT_EN
        drive(0, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) tick();
        chk("tmo.early_done", done_o, 0);
        chk("tmo.early_flag", timeout_o, 0);
        tick();
        chk("tmo.done", done_o, 1);
        chk("tmo.flag", timeout_o, 1);
        tick();
        chk("tmo.sticky", timeout_o, 1);
        drive(0, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
        chk("tmo.clear", timeout_o, 0);
        chk("tmo.busy", busy_o, 1);
        drive(0, 0, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
`else
        drive(0, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) tick();
        chk("notmo.busy", busy_o, 1);
        chk("notmo.flag", timeout_o, 0);
        drive(0, 0, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
        chk("notmo.stop", busy_o, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 SHALL have parameter PAT_W, default 4, pattern length in bits (2..8).
REQ-002 SHALL have parameter CNT_W, default 8, width of the match counter and limit.
REQ-003 SHALL have parameter TMO_W, default 6, width of the idle-timeout counter (used only with SEQ_DET_TIMEOUT_EN).
REQ-004 clk  input  1  sole clock; all logic on posedge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cfg_valid  input  1  configuration offer.
REQ-007 cfg_ready  output  1  high in IDLE and DONE only.
REQ-008 cfg_pattern  input  PAT_W  target pattern; MSB is the oldest bit.
REQ-009 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-010 cfg_limit  input  CNT_W  match count that ends a run; 0 = unlimited.
REQ-011 start  input  1  begins a run.
REQ-012 stop  input  1  aborts a run.
REQ-013 in / in_valid  input  1 / 1  serial data bit and its qualifier.
REQ-014 out  output  1  one-cycle match pulse, registered.
REQ-015 match_cnt  output  CNT_W  matches counted in the current run.
REQ-016 busy / done / timeout  output  1 each  in RUN / in DONE / sticky timeout flag.

Function
REQ-017 FSM states: IDLE, RUN, DONE; busy = (state==RUN), done = (state==DONE).
REQ-018 Config handshake: cfg_valid & cfg_ready captures pattern, overlap and limit on that edge; cfg_valid is ignored in RUN.
REQ-019 IDLE/DONE + start -> RUN; the same edge clears match_cnt, the history register, the fill count and timeout.
REQ-020 cfg handshake and start in the same cycle: config is captured, start is ignored, state is unchanged.
REQ-021 In RUN, each in_valid cycle shifts in into a PAT_W-bit history (LSB = newest) and increments fill, saturating at PAT_W; in_valid=0 cycles change nothing.
REQ-022 Match: in_valid & fill>=PAT_W-1 before the shift & {history[PAT_W-2:0],in}==pattern; out=1 on the next cycle (latency 1 from the final bit).
REQ-023 On a match with overlap=1, fill is unchanged; with overlap=0, fill and history clear to 0.
REQ-024 On a match, match_cnt increments and saturates at all-ones.
REQ-025 When match_cnt+1 == limit and limit!=0: RUN -> DONE on that edge; out still pulses; further bits are ignored.
REQ-026 stop in RUN -> IDLE; stop takes priority over a same-cycle match (no pulse, count unchanged); match_cnt is held.
REQ-027 stop in IDLE/DONE has no effect; DONE + start behaves as REQ-019.
REQ-028 out=0 in every cycle that is not exactly one after a counted match.

Reset
REQ-029 rst SHALL force state=IDLE, out=0, match_cnt=0, history=0, fill=0, timeout=0, pattern=0, overlap=0, limit=0, regardless of state; rst overrides all other inputs.
REQ-030 rst mid-run SHALL drop any pending match pulse; the first post-reset cycle has cfg_ready=1.

Configuration
REQ-031 Macro SEQ_DET_TIMEOUT_EN defined: in RUN, a counter counts consecutive cycles with in_valid=0 and clears when in_valid=1; reaching 2^TMO_W-1 -> DONE with timeout=1; timeout stays set until start or rst.
REQ-032 Macro SEQ_DET_TIMEOUT_EN undefined: no timeout counter; the timeout port is tied to 0; RUN exits only via limit, stop or rst.

Verification
REQ-033 pattern=0110, overlap=1, limit=0; start; bits 0,1,1,0,1,1,0 back-to-back -> out pulses the cycle after bit 4 and after bit 7; match_cnt=2; busy stays 1.
REQ-034 Same stream with overlap=0 -> single pulse after bit 4; match_cnt=1.
REQ-035 pattern=0110, limit=1; stream 0110 0110 -> one pulse; done=1 from the cycle after bit 4; match_cnt=1; cfg_ready=1.
REQ-036 Stream 0110 with in_valid=0 gaps of 3 cycles between bits -> exactly one pulse, one cycle after the last valid bit.
REQ-037 stop asserted on the cycle bit 4 of 0110 is valid -> no pulse; state=IDLE; match_cnt=0. Separately, rst mid-run -> all outputs 0 on the next cycle.
REQ-038 With SEQ_DET_TIMEOUT_EN and TMO_W=3: start, then 7 idle cycles -> timeout=1 and done=1; a following start clears timeout.
